// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard and branch-flush controller for the 5-stage pipeline.
// Stall decisions are combinational from FSM state and inputs; perf counters are saturating.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              MemRead_EX,
    input  logic              branch_taken,
    input  logic              clr_cnt,
    output logic              PC_write,
    output logic              IF_write,
    output logic              HazardMux,
    output logic              flush_IF,
    output logic              flush_ID,
    output logic              stalled,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hit;
    logic          stall_now;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hit = MemRead_EX && (rd_EX != '0) &&
                 ((use_rs1 && (rs1_ID == rd_EX)) || (use_rs2 && (rs2_ID == rd_EX)));

    // A taken branch squashes the consumer, so it overrides both a new hit and a pending stall.
    always_comb begin
        stall_now = 1'b0;
        if (!reset && !branch_taken) begin
            if (state == STALL)
                stall_now = 1'b1;
            else if (hit)
                stall_now = 1'b1;
        end
    end

    always_comb begin
        PC_write  = !stall_now;
        IF_write  = !stall_now;
        HazardMux = stall_now;
        flush_IF  = !reset && branch_taken;
        flush_ID  = !reset && branch_taken;
        stalled   = !reset && (state == STALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch_taken) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        cnt   <= CW'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    // The load is already past EX here, so further hits need no extra bubble.
                    if (cnt <= CW'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!PC_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (branch_taken && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4)
// share one stimulus stream; each step drives at negedge and checks before the next posedge.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       use_rs1, use_rs2, MemRead_EX, branch_taken, clr_cnt;

    logic        pc_a, ifw_a, hm_a, fi_a, fd_a, st_a;
    logic [31:0] sc_a, fc_a;
    logic        pc_b, ifw_b, hm_b, fi_b, fd_b, st_b;
    logic [31:0] sc_b, fc_b;
    logic        pc_c, ifw_c, hm_c, fi_c, fd_c, st_c;
    logic [3:0]  sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .PC_write(pc_a), .IF_write(ifw_a), .HazardMux(hm_a), .flush_IF(fi_a),
        .flush_ID(fd_a), .stalled(st_a), .stall_count(sc_a), .flush_count(fc_a));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .PC_write(pc_b), .IF_write(ifw_b), .HazardMux(hm_b), .flush_IF(fi_b),
        .flush_ID(fd_b), .stalled(st_b), .stall_count(sc_b), .flush_count(fc_b));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .PC_write(pc_c), .IF_write(ifw_c), .HazardMux(hm_c), .flush_IF(fi_c),
        .flush_ID(fd_c), .stalled(st_c), .stall_count(sc_c), .flush_count(fc_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, apply one cycle of inputs, let combinational outputs settle.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic clr, input logic rst);
        @(negedge clk);
        rs1_ID = rs1; rs2_ID = rs2; use_rs1 = u1; use_rs2 = u2;
        rd_EX = rd; MemRead_EX = mr; branch_taken = br; clr_cnt = clr; reset = rst;
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic quiesce();
        for (int i = 0; i < 4; i++) idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset with a hazard pattern present: outputs must be forced to defaults.
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_pc_write", 32'(pc_a), 32'd1);
        check("rst_if_write", 32'(ifw_a), 32'd1);
        check("rst_hazardmux", 32'(hm_b), 32'd0);
        check("rst_stalled", 32'(st_b), 32'd0);
        idle();
        check("rst_stall_count", sc_a, 32'd0);
        check("rst_flush_count", fc_b, 32'd0);

        // LOAD_LAT=1 classic single bubble on rs1.
        quiesce();
        drive(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat1_pc_write", 32'(pc_a), 32'd0);
        check("lat1_if_write", 32'(ifw_a), 32'd0);
        check("lat1_hazardmux", 32'(hm_a), 32'd1);
        check("lat1_stalled", 32'(st_a), 32'd0);
        idle();
        check("lat1_pc_after", 32'(pc_a), 32'd1);
        check("lat1_stall_count", sc_a, 32'd1);

        // Load into x0 never hazards.
        quiesce();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("x0_pc_write_a", 32'(pc_a), 32'd1);
        check("x0_pc_write_b", 32'(pc_b), 32'd1);
        check("x0_hazardmux", 32'(hm_b), 32'd0);
        idle();
        check("x0_stall_count", sc_b, 32'd0);

        // Match on rs1 but use_rs1 low: no hazard.
        drive(5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        check("unused_rs1_pc", 32'(pc_a), 32'd1);

        // LOAD_LAT=3 hit on rs2 only; hit held during stall must not extend it.
        quiesce();
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat3_c1_pc", 32'(pc_b), 32'd0);
        check("lat3_c1_stalled", 32'(st_b), 32'd0);
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat3_c2_pc", 32'(pc_b), 32'd0);
        check("lat3_c2_stalled", 32'(st_b), 32'd1);
        idle();
        check("lat3_c3_pc", 32'(pc_b), 32'd0);
        check("lat3_c3_hazardmux", 32'(hm_b), 32'd1);
        check("lat3_c3_stalled", 32'(st_b), 32'd1);
        idle();
        check("lat3_c4_pc", 32'(pc_b), 32'd1);
        check("lat3_c4_stalled", 32'(st_b), 32'd0);
        check("lat3_stall_count", sc_b, 32'd3);

        // LOAD_LAT=3 hit, then branch on the 2nd stall cycle aborts the stall.
        quiesce();
        drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_c1_pc", 32'(pc_b), 32'd0);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_flush_if", 32'(fi_b), 32'd1);
        check("abort_flush_id", 32'(fd_b), 32'd1);
        check("abort_pc", 32'(pc_b), 32'd1);
        check("abort_hazardmux", 32'(hm_b), 32'd0);
        idle();
        check("abort_idle_stalled", 32'(st_b), 32'd0);
        check("abort_idle_pc", 32'(pc_b), 32'd1);
        check("abort_flush_count", fc_b, 32'd1);
        check("abort_stall_count", sc_b, 32'd1);

        // Hit and branch together: flush only.
        quiesce();
        drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("both_flush_if", 32'(fi_b), 32'd1);
        check("both_hazardmux", 32'(hm_b), 32'd0);
        check("both_pc", 32'(pc_b), 32'd1);
        idle();
        check("both_stall_count", sc_b, 32'd0);
        check("both_flush_count", fc_b, 32'd1);
        check("both_stalled", 32'(st_b), 32'd0);

        // CNT_W=4 saturation, clear, and clear beating a same-cycle event.
        quiesce();
        for (int i = 0; i < 20; i++)
            drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("sat_stall_count", 32'(sc_c), 32'd15);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        check("clr_stall_count", 32'(sc_c), 32'd0);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        check("clr_drop_stall", 32'(sc_c), 32'd0);
        check("clr_drop_flush", 32'(fc_c), 32'd0);

        // Reset in the middle of a LOAD_LAT=3 stall.
        quiesce();
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rststall_c1_pc", 32'(pc_b), 32'd0);
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rststall_forced_pc", 32'(pc_b), 32'd1);
        check("rststall_forced_hm", 32'(hm_b), 32'd0);
        check("rststall_forced_st", 32'(st_b), 32'd0);
        idle();
        check("rststall_idle_stalled", 32'(st_b), 32'd0);
        check("rststall_idle_pc", 32'(pc_b), 32'd1);
        check("rststall_count", sc_b, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
